// File: rtl/pipelined_mux_nbit.sv
// rtl/pipelined_mux_nbit.sv - m-input n-bit registered selector with 2-entry skid buffer (optional MUX_PERF_CNT_EN)
module pipelined_mux_nbit #(
    parameter int n = 32,
    parameter int m = 4,
    localparam int SELW = $clog2(m)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SELW-1:0]   sel,
    input  logic [m*n-1:0]    data_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [n-1:0]      out,
    output logic              sel_err,
    output logic [31:0]       perf_beats
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]   state;
    logic [1:0]   next_state;
    logic         accept;
    logic         drain;
    logic         load_main;
    logic         load_skid;
    logic         main_from_skid;
    logic [n-1:0] beat_data;
    logic         beat_err;
    logic [n-1:0] main_data;
    logic         main_err;
    logic [n-1:0] skid_data;
    logic         skid_err;

    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    assign out_valid = (state != EMPTY);
    assign out       = main_data;
    assign sel_err   = main_err;

    // Select the addressed input; an out-of-range select yields zero data flagged as an error
    always_comb begin
        beat_data = '0;
        beat_err  = 1'b1;
        for (int k = 0; k < m; k++) begin
            if (int'(sel) == k) begin
                beat_data = data_in[k*n +: n];
                beat_err  = 1'b0;
            end
        end
    end

    // Occupancy transitions and register load controls; flush overrides everything
    always_comb begin
        next_state     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    next_state = ONE;
                    load_main  = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    next_state = TWO;
                    load_skid  = 1'b1;
                end else if (drain) begin
                    next_state = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    next_state     = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
        if (flush) begin
            next_state     = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    // State and registered ready: ready drops only while both entries are occupied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != TWO);
        end
    end

    // Main (head) and skid entries; the error flag travels with its beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= '0;
            main_err  <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
        end else if (flush) begin
            main_data <= '0;
            main_err  <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
        end else begin
            if (load_main) begin
                main_data <= beat_data;
                main_err  <= beat_err;
            end else if (main_from_skid) begin
                main_data <= skid_data;
                main_err  <= skid_err;
            end
            if (load_skid) begin
                skid_data <= beat_data;
                skid_err  <= beat_err;
            end
        end
    end

`ifdef MUX_PERF_CNT_EN
    logic [31:0] perf_q;

    // Saturating count of completed output transfers; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (drain && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_beats = perf_q;
`else
    assign perf_beats = 32'd0;
`endif

endmodule
